// File: rtl/shift_expander.sv
// rtl/shift_expander.sv - places a short signed/unsigned word into a long word at a programmable offset
// Valid/ready stream with a one-entry skid buffer; o_ready is registered.
module shift_expander #(
    parameter int L_width    = 32,
    parameter int S_width    = 16,
    parameter int Shift_word = 5,
    parameter int Signed     = 1
) (
    input  logic                  i_clkp,
    input  logic                  i_rstn,
    input  logic [S_width-1:0]    i_short,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [Shift_word-1:0] i_shift,
    input  logic                  i_shift_we,
    input  logic                  i_clr,
    output logic [L_width-1:0]    o_long,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [Shift_word-1:0] o_shift_cur,
    output logic                  o_shift_clip
);

    localparam int D_WORD = L_width - S_width;
    localparam logic [Shift_word-1:0] D_SHIFT = Shift_word'(D_WORD);

    logic [L_width-1:0]    out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic [L_width-1:0]    skid_q, skid_d;
    logic                  skid_full_q, skid_full_d;
    logic                  ready_q, ready_d;
    logic [Shift_word-1:0] shift_q, shift_d;
    logic                  clip_q, clip_d;

    logic                  sign_bit;
    logic [L_width-1:0]    ext_word;
    logic [L_width-1:0]    placed;
    logic                  accept;
    logic                  clip_write;

    always_comb begin
        sign_bit    = (Signed != 0) && i_short[S_width-1];
        ext_word    = {{D_WORD{sign_bit}}, i_short};
        placed      = ext_word << shift_q;
        accept      = i_valid & ready_q;
        clip_write  = i_shift_we && (i_shift > D_SHIFT);

        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        shift_d     = shift_q;
        clip_d      = clip_q;

        // ready_q is low whenever the skid is full, so the skid never receives while draining
        if (!out_valid_q || i_ready) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = placed;
                end
            end
        end else if (accept) begin
            skid_d      = placed;
            skid_full_d = 1'b1;
        end

        ready_d = !skid_full_d;

        if (i_shift_we) begin
            shift_d = clip_write ? D_SHIFT : i_shift;
        end
        if (i_clr) begin
            clip_d = 1'b0;
        end
        if (clip_write) begin
            clip_d = 1'b1;
        end
    end

    always_ff @(posedge i_clkp) begin
        if (!i_rstn) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            ready_q     <= 1'b1;
            shift_q     <= '0;
            clip_q      <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            ready_q     <= ready_d;
            shift_q     <= shift_d;
            clip_q      <= clip_d;
        end
    end

    assign o_long       = out_q;
    assign o_valid      = out_valid_q;
    assign o_ready      = ready_q;
    assign o_shift_cur  = shift_q;
    assign o_shift_clip = clip_q;

endmodule

// File: tb/tb_shift_expander.sv
// tb/tb_shift_expander.sv - bench for shift_expander (signed and unsigned instances)
// Reference is a depth-2 FIFO of precomputed results plus a shift/clip register model.
module tb_shift_expander;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] i_short;
    logic        i_valid;
    logic [4:0]  i_shift;
    logic        i_shift_we;
    logic        i_clr;
    logic        i_ready;

    logic        o_ready_s, o_valid_s, o_clip_s;
    logic [31:0] o_long_s;
    logic [4:0]  o_shift_s;
    logic        o_ready_u, o_valid_u, o_clip_u;
    logic [31:0] o_long_u;
    logic [4:0]  o_shift_u;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    shift_expander #(.L_width(32), .S_width(16), .Shift_word(5), .Signed(1)) u_dut_s (
        .i_clkp(clk), .i_rstn(rstn), .i_short(i_short), .i_valid(i_valid), .o_ready(o_ready_s),
        .i_shift(i_shift), .i_shift_we(i_shift_we), .i_clr(i_clr), .o_long(o_long_s),
        .o_valid(o_valid_s), .i_ready(i_ready), .o_shift_cur(o_shift_s), .o_shift_clip(o_clip_s)
    );

    shift_expander #(.L_width(32), .S_width(16), .Shift_word(5), .Signed(0)) u_dut_u (
        .i_clkp(clk), .i_rstn(rstn), .i_short(i_short), .i_valid(i_valid), .o_ready(o_ready_u),
        .i_shift(i_shift), .i_shift_we(i_shift_we), .i_clr(i_clr), .o_long(o_long_u),
        .o_valid(o_valid_u), .i_ready(i_ready), .o_shift_cur(o_shift_u), .o_shift_clip(o_clip_u)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pipe holds {signed_result, unsigned_result} in arrival order
    logic [63:0] pipe[$];
    int          m_shift = 0;
    bit          m_clip  = 1'b0;

    always @(negedge clk) begin
        logic signed [31:0] sx;
        logic [31:0]        zx;
        bit                 pop, push;
        if (started) begin
            chk("o_valid_s", {31'b0, o_valid_s}, {31'b0, pipe.size() > 0});
            chk("o_valid_u", {31'b0, o_valid_u}, {31'b0, pipe.size() > 0});
            chk("o_ready_s", {31'b0, o_ready_s}, {31'b0, pipe.size() < 2});
            chk("o_ready_u", {31'b0, o_ready_u}, {31'b0, pipe.size() < 2});
            chk("shift_cur", {27'b0, o_shift_s}, 32'(m_shift));
            chk("shift_clip", {31'b0, o_clip_s}, {31'b0, m_clip});
            if (pipe.size() > 0) begin
                chk("o_long_s", o_long_s, pipe[0][63:32]);
                chk("o_long_u", o_long_u, pipe[0][31:0]);
            end
        end
        if (!rstn) begin
            pipe.delete();
            m_shift = 0;
            m_clip  = 1'b0;
        end else begin
            pop  = (pipe.size() > 0) && i_ready;
            push = i_valid && (pipe.size() < 2);
            sx   = $signed(i_short);
            zx   = {16'b0, i_short};
            if (pop) void'(pipe.pop_front());
            if (push) pipe.push_back({sx * (32'sd1 <<< m_shift), zx * (32'd1 << m_shift)});
            if (i_clr) m_clip = 1'b0;
            if (i_shift_we) begin
                if (int'(i_shift) > 16) begin
                    m_shift = 16;
                    m_clip  = 1'b1;
                end else begin
                    m_shift = int'(i_shift);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; i_short = '0; i_valid = 1'b0; i_shift = '0;
        i_shift_we = 1'b0; i_clr = 1'b0; i_ready = 1'b1;
        cyc(); cyc();
        rstn = 1'b1;
        started = 1'b1;
        chk("rst_valid", {31'b0, o_valid_s}, 32'd0);
        chk("rst_ready", {31'b0, o_ready_s}, 32'd1);
        chk("rst_long", o_long_s, 32'd0);
        chk("rst_shift", {27'b0, o_shift_s}, 32'd0);
        chk("rst_clip", {31'b0, o_clip_s}, 32'd0);

        // extension
        i_shift = 5'd4; i_shift_we = 1'b1; cyc(); i_shift_we = 1'b0;
        i_short = 16'h8001; i_valid = 1'b1; cyc();
        chk("ext_neg", o_long_s, 32'hFFF80010);
        chk("ext_neg_v", {31'b0, o_valid_s}, 32'd1);
        chk("zext", o_long_u, 32'h00080010);
        i_short = 16'h7FFF; cyc();
        chk("ext_pos", o_long_s, 32'h0007FFF0);
        i_valid = 1'b0; cyc();

        // clamp and sticky clip
        i_shift = 5'd20; i_shift_we = 1'b1; cyc(); i_shift_we = 1'b0;
        chk("clamp_shift", {27'b0, o_shift_s}, 32'd16);
        chk("clamp_clip", {31'b0, o_clip_s}, 32'd1);
        i_short = 16'h0001; i_valid = 1'b1; cyc(); i_valid = 1'b0;
        chk("clamp_out", o_long_s, 32'h00010000);
        i_clr = 1'b1; cyc(); i_clr = 1'b0;
        chk("clr_clip", {31'b0, o_clip_s}, 32'd0);
        i_shift_we = 1'b1; i_clr = 1'b1; cyc(); i_shift_we = 1'b0; i_clr = 1'b0;
        chk("set_wins", {31'b0, o_clip_s}, 32'd1);

        // shift timing: same-cycle write uses the old shift
        i_shift = 5'd0; i_shift_we = 1'b1; cyc();
        i_shift = 5'd8; i_short = 16'h0001; i_valid = 1'b1; cyc(); i_shift_we = 1'b0;
        chk("old_shift", o_long_s, 32'h00000001);
        cyc(); i_valid = 1'b0;
        chk("new_shift", o_long_s, 32'h00000100);
        cyc();

        // backpressure
        i_shift = 5'd0; i_shift_we = 1'b1; cyc(); i_shift_we = 1'b0;
        i_ready = 1'b0; i_valid = 1'b1; i_short = 16'd1; cyc();
        i_short = 16'd2; cyc();
        chk("bp_ready_lo", {31'b0, o_ready_s}, 32'd0);
        i_short = 16'd3; cyc();
        chk("bp_hold_ready", {31'b0, o_ready_s}, 32'd0);
        chk("bp_hold_out", o_long_s, 32'd1);
        i_ready = 1'b1; cyc();
        chk("bp_drain2", o_long_s, 32'd2);
        chk("bp_ready_hi", {31'b0, o_ready_s}, 32'd1);
        cyc(); i_valid = 1'b0;
        chk("bp_drain3", o_long_s, 32'd3);
        cyc();
        chk("bp_empty", {31'b0, o_valid_s}, 32'd0);

        // reset mid-operation
        i_shift = 5'd5; i_shift_we = 1'b1; cyc(); i_shift_we = 1'b0;
        i_ready = 1'b0; i_valid = 1'b1; i_short = 16'h1234; cyc(); cyc();
        rstn = 1'b0; cyc(); rstn = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        chk("mid_rst_valid", {31'b0, o_valid_s}, 32'd0);
        chk("mid_rst_ready", {31'b0, o_ready_s}, 32'd1);
        chk("mid_rst_shift", {27'b0, o_shift_s}, 32'd0);
        i_valid = 1'b1; i_short = 16'h0042; cyc(); i_valid = 1'b0;
        chk("restart", o_long_s, 32'h00000042);

        // randomized traffic checked by the model
        for (int i = 0; i < 4000; i++) begin
            i_valid    = ($urandom_range(0, 3) != 0);
            i_ready    = ($urandom_range(0, 2) != 0);
            i_short    = 16'($urandom);
            i_shift_we = ($urandom_range(0, 15) == 0);
            i_shift    = 5'($urandom);
            i_clr      = ($urandom_range(0, 31) == 0);
            rstn       = ($urandom_range(0, 499) != 0);
            cyc();
        end
        rstn = 1'b1; i_valid = 1'b0; i_shift_we = 1'b0; i_clr = 1'b0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
